// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding, line levels and the
// parity helper used by both the transmit and receive sides.
package uart_pkg;

  localparam int   UART_DATA_W = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Even parity when odd=0, odd parity when odd=1.
  function automatic logic calc_parity(input logic [UART_DATA_W-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte write port of the UART transmitter: write strobe and data in,
// FIFO status flags back to the producer.
interface uart_tx_if #(
  parameter int DATA_W = 8
);
  logic              wr_en;
  logic [DATA_W-1:0] d_in;
  logic              tx_full;
  logic              tx_empty;

  modport master (
    output wr_en,
    output d_in,
    input  tx_full,
    input  tx_empty
  );

  modport slave (
    input  wr_en,
    input  d_in,
    output tx_full,
    output tx_empty
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Show-ahead synchronous FIFO feeding the UART transmitter; head word is
// visible on d_out so the FSM can load it on the same edge it pops.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic              full_reg;
  logic              empty_reg;
  logic              push;
  logic              pop;

  // A write while full is dropped even if a pop frees a slot this cycle.
  assign push = wr_en & ~full_reg;
  assign pop  = rd_en & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(FIFO_DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= d_in;
    end
  end

  assign d_out = mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers bytes in a FIFO and serialises them as
// start, DATA_W data bits LSB first, optional parity and one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       b_clk_tx,
  input  logic       parity_en,
  input  logic       parity_odd,
  uart_tx_if.slave   bus,
  output logic       tx,
  output logic       tx_busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_t         state_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              par_en_reg;
  logic              par_bit_reg;
  logic              tx_reg;
  logic              busy_reg;

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              frame_par;

  // New frames are only loaded from IDLE or at the end of a stop bit.
  assign pop = b_clk_tx & ~fifo_empty & ((state_reg == IDLE) | (state_reg == STOP));
  assign frame_par = calc_parity(UART_DATA_W'(fifo_dout), parity_odd);

  uart_tx_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .wr_en(bus.wr_en),
    .rd_en(pop),
    .d_in (bus.d_in),
    .d_out(fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
      tx_reg      <= IDLE_LEVEL;
      busy_reg    <= 1'b0;
    end else if (b_clk_tx) begin
      case (state_reg)
        IDLE, STOP: begin
          if (!fifo_empty) begin
            // Parity config is frozen here for the whole frame.
            shift_reg   <= fifo_dout;
            par_en_reg  <= parity_en;
            par_bit_reg <= frame_par;
            state_reg   <= START;
            tx_reg      <= START_LEVEL;
            busy_reg    <= 1'b1;
          end else begin
            state_reg <= IDLE;
            tx_reg    <= IDLE_LEVEL;
            busy_reg  <= 1'b0;
          end
        end
        START: begin
          state_reg   <= DATA;
          bit_cnt_reg <= '0;
          tx_reg      <= shift_reg[0];
        end
        DATA: begin
          shift_reg   <= shift_reg >> 1;
          bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
          if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
            bit_cnt_reg <= '0;
            if (par_en_reg) begin
              state_reg <= PARITY;
              tx_reg    <= par_bit_reg;
            end else begin
              state_reg <= STOP;
              tx_reg    <= STOP_LEVEL;
            end
          end else begin
            tx_reg <= shift_reg[1];
          end
        end
        PARITY: begin
          state_reg <= STOP;
          tx_reg    <= STOP_LEVEL;
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= IDLE_LEVEL;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign tx           = tx_reg;
  assign tx_busy      = busy_reg;
  assign bus.tx_full  = fifo_full;
  assign bus.tx_empty = fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line
// monitor decodes tx at every baud tick and checks each frame.
module tb_uart_tx;

  logic clk;
  logic reset;
  logic b_clk_tx;
  logic parity_en;
  logic parity_odd;
  logic tx;
  logic tx_busy;
  logic tick_en;
  int   div;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pb;
    logic       b2b;
  } exp_t;

  exp_t exp_q[$];
  logic mon_busy;

  uart_tx_if #(.DATA_W(8)) bus ();

  uart_tx #(.DATA_W(8), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .b_clk_tx  (b_clk_tx),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .bus       (bus),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: one-cycle pulse every 7 clocks while enabled.
  initial begin
    div      = 0;
    b_clk_tx = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en && div == 6) begin
        b_clk_tx = 1'b1;
        div      = 0;
      end else begin
        b_clk_tx = 1'b0;
        if (tick_en) div++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic pb, input logic b2b);
    exp_t e;
    e.data = d;
    e.pe   = pe;
    e.pb   = pb;
    e.b2b  = b2b;
    return e;
  endfunction

  // Line monitor: samples tx just after every tick edge.
  initial begin : monitor
    int   st;
    int   n;
    int   idle_cnt;
    logic cur_valid;
    exp_t cur;
    logic [7:0] got;
    logic got_par;
    st        = 0;
    n         = 0;
    idle_cnt  = 0;
    cur_valid = 1'b0;
    got       = '0;
    got_par   = 1'b0;
    cur       = mk(8'h00, 1'b0, 1'b0, 1'b0);
    mon_busy  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        st       = 0;
        idle_cnt = 0;
        mon_busy = 1'b0;
      end else if (b_clk_tx) begin
        case (st)
          0: begin
            if (tx == 1'b0) begin
              mon_busy = 1'b1;
              if (exp_q.size() == 0) begin
                cur_valid = 1'b0;
                errors++;
                checks++;
                $display("FAIL unexpected_frame: got start bit, required idle line");
              end else begin
                cur       = exp_q.pop_front();
                cur_valid = 1'b1;
                if (cur.b2b) chk("b2b_gap", idle_cnt, 0);
              end
              n  = 0;
              st = 1;
            end else begin
              idle_cnt++;
            end
          end
          1: begin
            got[n] = tx;
            n++;
            if (n == 8) st = (cur_valid && cur.pe) ? 2 : 3;
          end
          2: begin
            got_par = tx;
            st      = 3;
          end
          default: begin
            chk("stop_bit", tx, 1);
            if (cur_valid) begin
              chk("frame_data", got, cur.data);
              if (cur.pe) chk("parity_bit", got_par, cur.pb);
              $display("frame data=%02h exp=%02h pe=%0b par=%0b", got, cur.data, cur.pe, got_par);
            end
            idle_cnt = 0;
            st       = 0;
            mon_busy = 1'b0;
          end
        endcase
      end
    end
  end

  task automatic wr_byte(input logic [7:0] v);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.d_in  = v;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_busy && !tx_busy && bus.tx_empty) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: got frames still pending=%0d, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_busy_rise(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_busy) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL %s_busy_timeout: got tx_busy=0, required 1", name);
    end
  endtask

  task automatic wait_ticks(input int k);
    int seen;
    seen = 0;
    while (seen < k) begin
      @(posedge clk);
      if (b_clk_tx) seen++;
    end
  endtask

  initial begin : stim
    int   n;
    logic low_seen;
    reset      = 1'b1;
    tick_en    = 1'b0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    bus.wr_en  = 1'b0;
    bus.d_in   = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", tx_busy, 0);
    chk("reset_empty", bus.tx_empty, 1);
    chk("reset_full", bus.tx_full, 0);
    reset = 1'b0;
    @(negedge clk);
    tick_en = 1'b1;

    // Even parity 0xA5, frame length 11 bits x 7 clk.
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    exp_q.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b0));
    wr_byte(8'hA5);
    wait_busy_rise("even");
    n = 0;
    while (tx_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, 77);
    chk("after_even_empty", bus.tx_empty, 1);
    chk("after_even_tx", tx, 1);
    wait_done("even");

    // Odd parity, two queued frames.
    parity_odd = 1'b1;
    exp_q.push_back(mk(8'hA5, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(8'h01, 1'b1, 1'b0, 1'b1));
    wr_byte(8'hA5);
    wr_byte(8'h01);
    wait_done("odd");

    // No parity, three writes on consecutive cycles.
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'hFF, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.d_in  = 8'h00;
    @(negedge clk);
    bus.d_in  = 8'hFF;
    @(negedge clk);
    bus.d_in  = 8'h3C;
    @(negedge clk);
    bus.wr_en = 1'b0;
    wait_done("b2b");

    // Fill with ticks held off; ninth write is dropped.
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 7) chk("full_before_8th", bus.tx_full, 0);
      if (i == 8) chk("full_after_8th", bus.tx_full, 1);
      bus.wr_en = 1'b1;
      bus.d_in  = 8'h10 + 8'(i);
      if (i < 8) exp_q.push_back(mk(8'h10 + 8'(i), 1'b0, 1'b0, (i != 0)));
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("full_after_drop", bus.tx_full, 1);
    chk("no_tick_busy", tx_busy, 0);
    chk("no_tick_empty", bus.tx_empty, 0);
    tick_en = 1'b1;
    wait_done("overflow");

    // Reset during data bit 3 aborts the frame.
    exp_q.push_back(mk(8'hC3, 1'b0, 1'b0, 1'b0));
    wr_byte(8'hC3);
    wait_busy_rise("abort");
    wait_ticks(4);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_busy", tx_busy, 0);
    chk("rst_mid_empty", bus.tx_empty, 1);
    repeat (10) @(negedge clk);
    reset    = 1'b0;
    low_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    chk("idle_after_reset", low_seen, 0);
    chk("abort_frame_consumed", exp_q.size(), 0);
    exp_q.push_back(mk(8'h5A, 1'b0, 1'b0, 1'b0));
    wr_byte(8'h5A);
    wait_done("after_reset");

    // Parity config changed mid-frame only affects the next frame.
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    exp_q.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(8'hA5, 1'b1, 1'b1, 1'b1));
    wr_byte(8'hA5);
    wr_byte(8'hA5);
    wait_busy_rise("latch");
    wait_ticks(3);
    @(negedge clk);
    parity_odd = 1'b1;
    wait_done("latch");

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
